sr_prbs_checker: RTL and testbench

SR_PRBS_CHECKER -- requirements
Module: sr_prbs_checker

---
 rtl/sr_prbs_pkg.sv | 31 +++
 rtl/sr_prbs7_lfsr.sv | 46 ++++
 rtl/sr_prbs_checker.sv | 175 +++++++++++++++++
 tb/tb_sr_prbs_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_prbs_pkg.sv
// ============================================================================
// Module  : sr_prbs_pkg
// Brief   : Shared PRBS7 constants, FSM state encoding and prediction helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_prbs_pkg;

  localparam int PRBS_ORDER = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;
  localparam int WIN_LEN    = 64;
  localparam int WIN_W      = $clog2(WIN_LEN);
  localparam int FILL_W     = $clog2(PRBS_ORDER + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } prbs_state_e;

  // x^7 + x^6 + 1: next bit is the XOR of the two oldest history bits
  function automatic logic prbs7_predict(input logic [PRBS_ORDER-1:0] hist);
    return hist[PRBS_TAP_A] ^ hist[PRBS_TAP_B];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_prbs7_lfsr.sv
// ============================================================================
// Module  : sr_prbs7_lfsr
// Brief   : PRBS7 history register with predicted-next-bit output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_prbs7_lfsr
  import sr_prbs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic                  din_i,
  output logic [PRBS_ORDER-1:0] hist_o,
  output logic                  pred_o
);

  logic [PRBS_ORDER-1:0] hist_q;
  logic [PRBS_ORDER-1:0] hist_d;

  // A generator feeds pred_o back into din_i; a checker feeds received data
  always_comb begin
    hist_d = hist_q;
    if (clr_i) begin
      hist_d = '0;
    end else if (shift_i) begin
      hist_d = {hist_q[PRBS_ORDER-2:0], din_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist_o = hist_q;
  assign pred_o = prbs7_predict(hist_q);

endmodule

`default_nettype wire

// File: rtl/sr_prbs_checker.sv
// ============================================================================
// Module  : sr_prbs_checker
// Brief   : PRBS7 sync/lock checker with windowed loss detection and error count.
//           Define SR_PRBS_CHECKER_BITCNT_EN to enable the locked-sample counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_prbs_checker
  import sr_prbs_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 sample_bit,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          bit_count,
  output logic [1:0]           state
);

  prbs_state_e           state_q, state_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [WIN_W-1:0]      werr_q, werr_d;
  logic [WIN_W-1:0]      werr_base;
  logic [WIN_W-1:0]      werr_inc;
  logic [ERR_CNT_W-1:0]  errcnt_q, errcnt_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  locked_q;
  logic                  shift;
  logic                  pred;
  logic [PRBS_ORDER-1:0] hist;
  logic [PRBS_ORDER-1:0] next_hist;

  sr_prbs7_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clear),
    .shift_i (shift),
    .din_i   (sample_bit),
    .hist_o  (hist),
    .pred_o  (pred)
  );

  assign next_hist = {hist[PRBS_ORDER-2:0], sample_bit};

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    win_d       = win_q;
    werr_d      = werr_q;
    errcnt_d    = errcnt_q;
    err_pulse_d = 1'b0;
    shift       = 1'b0;
    werr_base   = werr_q;
    werr_inc    = werr_q;
    if (clear) begin
      state_d  = IDLE;
      fill_d   = '0;
      win_d    = '0;
      werr_d   = '0;
      errcnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_en) begin
            shift   = 1'b1;
            fill_d  = FILL_W'(1);
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (sample_en) begin
            shift = 1'b1;
            if (fill_q == FILL_W'(PRBS_ORDER - 1)) begin
              fill_d = '0;
              if (next_hist != '0) begin
                state_d = LOCKED;
              end
            end else begin
              fill_d = fill_q + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (sample_en) begin
            shift = 1'b1;
            // Window wrap clears the error tally before this sample is scored
            if (win_q == WIN_W'(WIN_LEN - 1)) begin
              win_d     = '0;
              werr_base = '0;
            end else begin
              win_d     = win_q + 1'b1;
              werr_base = werr_q;
            end
            werr_inc = werr_base + 1'b1;
            werr_d   = werr_base;
            if (sample_bit != pred) begin
              err_pulse_d = 1'b1;
              werr_d      = werr_inc;
              if (errcnt_q != {ERR_CNT_W{1'b1}}) begin
                errcnt_d = errcnt_q + 1'b1;
              end
              if (werr_inc == WIN_W'(LOSS_THRESH)) begin
                state_d = LOST;
              end
            end
          end
        end
        LOST: begin
          state_d = SYNC;
          fill_d  = '0;
          win_d   = '0;
          werr_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      errcnt_q    <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      errcnt_q    <= errcnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= (state_d == LOCKED);
    end
  end

`ifdef SR_PRBS_CHECKER_BITCNT_EN
  logic [31:0] bitcnt_q;
  logic        bitcnt_inc;

  assign bitcnt_inc = !clear && sample_en && (state_q == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_q <= '0;
    end else if (clear) begin
      bitcnt_q <= '0;
    end else if (bitcnt_inc) begin
      bitcnt_q <= bitcnt_q + 32'd1;
    end
  end

  assign bit_count = bitcnt_q;
`else
  assign bit_count = '0;
`endif

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = errcnt_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_prbs_checker.sv
// ============================================================================
// Module  : tb_sr_prbs_checker
// Brief   : Directed self-checking bench for sr_prbs_checker (default and
//           ERR_CNT_W=4 instances). Honours SR_PRBS_CHECKER_BITCNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        sample_bit;
  logic        clear;

  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;
  logic [1:0]  state;

  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;
  logic [31:0] bit_count4;
  logic [1:0]  state4;

  int          errors = 0;
  int          checks = 0;
  logic [6:0]  gen_s;
  logic        b;

`ifdef SR_PRBS_CHECKER_BITCNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  sr_prbs_checker dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .sample_bit (sample_bit),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .bit_count  (bit_count),
    .state      (state)
  );

  sr_prbs_checker #(.ERR_CNT_W(4), .LOSS_THRESH(63)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .sample_bit (sample_bit),
    .clear      (clear),
    .locked     (locked4),
    .err_pulse  (err_pulse4),
    .err_count  (err_count4),
    .bit_count  (bit_count4),
    .state      (state4)
  );

  function automatic logic [31:0] exp_bc(input int n);
    return BC_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic bit_in);
    sample_en  = en;
    sample_bit = bit_in;
    @(posedge clk);
    #1;
    sample_en  = 1'b0;
  endtask

  task automatic gen_next(output logic nb);
    nb    = gen_s[6] ^ gen_s[5];
    gen_s = {gen_s[5:0], nb};
  endtask

  task automatic send_clean(input int n);
    logic cb;
    for (int i = 0; i < n; i++) begin
      gen_next(cb);
      step(1'b1, cb);
    end
  endtask

  task automatic do_clear();
    clear     = 1'b1;
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    clear     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; sample_bit = 1'b0; clear = 1'b0;
    #12;
    chk("rst_state",     32'(state),     32'd0);
    chk("rst_locked",    32'(locked),    32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_bit_count", bit_count,      32'd0);
    chk("rst_bit_count4", bit_count4,    32'd0);
    rst = 1'b0;

    // Clean PRBS7 from seed 7F: locks on the 7th sample, 193 checked samples
    gen_s = 7'h7F;
    send_clean(6);
    chk("fill6_state",  32'(state),  32'd1);
    chk("fill6_locked", 32'(locked), 32'd0);
    send_clean(1);
    chk("fill7_state",   32'(state),   32'd2);
    chk("fill7_locked",  32'(locked),  32'd1);
    chk("fill7_locked4", 32'(locked4), 32'd1);
    send_clean(193);
    chk("clean_err_count", 32'(err_count), 32'd0);
    chk("clean_bit_count", bit_count,      exp_bc(193));
    chk("clean_err_pulse", 32'(err_pulse), 32'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("hold_bit_count", bit_count,  exp_bc(193));
    chk("hold_state",     32'(state), 32'd2);

    // Single inverted bit
    gen_next(b);
    step(1'b1, ~b);
    chk("single_err_pulse", 32'(err_pulse), 32'd1);
    chk("single_err_count", 32'(err_count), 32'd1);
    chk("single_locked",    32'(locked),    32'd1);
    step(1'b0, 1'b0);
    chk("single_pulse_end", 32'(err_pulse), 32'd0);

    do_clear();
    chk("clr_state",     32'(state),     32'd0);
    chk("clr_err_count", 32'(err_count), 32'd0);
    chk("clr_bit_count", bit_count,      32'd0);

    // Four errors in one window -> LOST for one cycle -> SYNC -> relock
    gen_s = 7'h7F;
    send_clean(17);
    for (int i = 0; i < 3; i++) begin
      gen_next(b);
      step(1'b1, ~b);
    end
    chk("loss3_state",     32'(state),     32'd2);
    chk("loss3_err_count", 32'(err_count), 32'd3);
    gen_next(b);
    step(1'b1, ~b);
    chk("loss4_state",     32'(state),     32'd3);
    chk("loss4_locked",    32'(locked),    32'd0);
    chk("loss4_err_pulse", 32'(err_pulse), 32'd1);
    chk("loss4_err_count", 32'(err_count), 32'd4);
    step(1'b1, 1'b1);
    chk("lost_to_sync", 32'(state), 32'd1);
    send_clean(6);
    chk("resync6_state", 32'(state), 32'd1);
    send_clean(1);
    chk("relock_state",  32'(state),  32'd2);
    chk("relock_locked", 32'(locked), 32'd1);
    send_clean(5);
    chk("relock_err_count", 32'(err_count), 32'd4);

    // Error on the wrapping sample restarts the window tally at 1
    do_clear();
    gen_s = 7'h7F;
    send_clean(67);
    for (int i = 0; i < 3; i++) begin
      gen_next(b);
      step(1'b1, ~b);
    end
    chk("wrap3_state", 32'(state), 32'd2);
    gen_next(b);
    step(1'b1, ~b);
    chk("wrap_err_state", 32'(state),     32'd2);
    chk("wrap_err_count", 32'(err_count), 32'd4);
    chk("wrap_err_pulse", 32'(err_pulse), 32'd1);

    // All-zero fill must not lock
    do_clear();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    chk("zero_fill_state",  32'(state),  32'd1);
    chk("zero_fill_locked", 32'(locked), 32'd0);
    gen_s = 7'h7F;
    send_clean(6);
    chk("zero_refill6_state", 32'(state), 32'd1);
    send_clean(1);
    chk("zero_relock_state", 32'(state), 32'd2);

    // Narrow counter saturation (loss threshold out of reach)
    do_clear();
    gen_s = 7'h7F;
    send_clean(7);
    chk("sat_locked4", 32'(locked4), 32'd1);
    for (int i = 0; i < 14; i++) begin
      b     = ~(gen_s[6] ^ gen_s[5]);
      gen_s = {gen_s[5:0], b};
      step(1'b1, b);
    end
    chk("sat14_err_count4", 32'(err_count4), 32'd14);
    chk("sat14_err_pulse4", 32'(err_pulse4), 32'd1);
    for (int i = 0; i < 6; i++) begin
      b     = ~(gen_s[6] ^ gen_s[5]);
      gen_s = {gen_s[5:0], b};
      step(1'b1, b);
      if (i == 0) chk("sat15_err_count4", 32'(err_count4), 32'd15);
    end
    chk("sat20_err_count4", 32'(err_count4), 32'd15);
    chk("sat20_state4",     32'(state4),     32'd2);

    // Asynchronous reset while locked
    do_clear();
    gen_s = 7'h7F;
    send_clean(20);
    gen_next(b);
    step(1'b1, ~b);
    chk("pre_rst_err_count", 32'(err_count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state",     32'(state),     32'd0);
    chk("arst_locked",    32'(locked),    32'd0);
    chk("arst_err_pulse", 32'(err_pulse), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_bit_count", bit_count,      32'd0);
    #2;
    rst = 1'b0;
    gen_s = 7'h7F;
    send_clean(7);
    chk("post_rst_locked", 32'(locked), 32'd1);
    send_clean(3);

    // Clear wins over a coincident erroneous sample
    gen_next(b);
    clear      = 1'b1;
    sample_en  = 1'b1;
    sample_bit = ~b;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    sample_en = 1'b0;
    chk("clr_en_state",     32'(state),     32'd0);
    chk("clr_en_locked",    32'(locked),    32'd0);
    chk("clr_en_err_pulse", 32'(err_pulse), 32'd0);
    chk("clr_en_err_count", 32'(err_count), 32'd0);
    chk("clr_en_bit_count", bit_count,      32'd0);
    step(1'b0, 1'b0);
    chk("clr_en_pulse_after", 32'(err_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
